dx_stage_reg: RTL and testbench

- Parametrised decode-to-execute pipeline register that replaces the fixed two-operand decode/execute stage register.
- Adds the following over that block:
  - Internal N-source priority forwarding, using address compare instead of external select signals.
  - A valid bit and a separate flush.
  - Forwarding refresh of held operands while stalled.
  - A saturating stall-cycle counter.
- Sits between the decode and execute stages. The hazard unit drives only stall and flush.

---
 rtl/stage_pkg.sv | 17 +
 rtl/dx_stage_reg_if.sv | 51 +++++
 rtl/fwd_select.sv | 33 +++
 rtl/dx_stage_reg.sv | 145 ++++++++++++++
 tb/tb_dx_stage_reg.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | stage_pkg : shared constants and operand type for the D/X stage        |
// | Revision  : 1.0                                                        |
// +-----------------------------------------------------------------------+
package stage_pkg;
  localparam int REG_ZERO   = 0;
  localparam int CTRL_NOP   = 0;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } src_op_t;
endpackage
`default_nettype wire

// File: rtl/dx_stage_reg_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dx_stage_reg_if : decode, forwarding and execute-side stage bus        |
// | Revision        : 1.0                                                  |
// +-----------------------------------------------------------------------+
interface dx_stage_reg_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int PC_W    = 32,
  parameter int CTRL_W  = 16,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
);
  logic                             stall;
  logic                             flush;
  logic                             in_valid;
  logic [PC_W-1:0]                  in_pc;
  logic [CTRL_W-1:0]                in_ctrl;
  logic [NUM_SRC-1:0][ADDR_W-1:0]   in_src_addr;
  logic [NUM_SRC-1:0][DATA_W-1:0]   in_src_data;
  logic [ADDR_W-1:0]                in_rd_addr;
  logic [DATA_W-1:0]                in_imm;
  logic [NUM_FWD-1:0]               fwd_valid;
  logic [NUM_FWD-1:0][ADDR_W-1:0]   fwd_addr;
  logic [NUM_FWD-1:0][DATA_W-1:0]   fwd_data;
  logic                             out_valid;
  logic [PC_W-1:0]                  out_pc;
  logic [CTRL_W-1:0]                out_ctrl;
  logic [NUM_SRC-1:0][ADDR_W-1:0]   out_src_addr;
  logic [NUM_SRC-1:0][DATA_W-1:0]   out_src_data;
  logic [ADDR_W-1:0]                out_rd_addr;
  logic [DATA_W-1:0]                out_imm;
  logic [NUM_SRC-1:0]               out_fwd_hit;
  logic [CNT_W-1:0]                 stall_cnt;

  modport master (
    output stall, flush, in_valid, in_pc, in_ctrl, in_src_addr, in_src_data,
           in_rd_addr, in_imm, fwd_valid, fwd_addr, fwd_data,
    input  out_valid, out_pc, out_ctrl, out_src_addr, out_src_data,
           out_rd_addr, out_imm, out_fwd_hit, stall_cnt
  );

  modport slave (
    input  stall, flush, in_valid, in_pc, in_ctrl, in_src_addr, in_src_data,
           in_rd_addr, in_imm, fwd_valid, fwd_addr, fwd_data,
    output out_valid, out_pc, out_ctrl, out_src_addr, out_src_data,
           out_rd_addr, out_imm, out_fwd_hit, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fwd_select : priority forwarding match and mux for one source operand  |
// | Revision   : 1.0                                                       |
// +-----------------------------------------------------------------------+
module fwd_select
  import stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic [ADDR_W-1:0]                addr,
  input  logic [DATA_W-1:0]                raw_data,
  input  logic [NUM_FWD-1:0]               fwd_valid,
  input  logic [NUM_FWD-1:0][ADDR_W-1:0]   fwd_addr,
  input  logic [NUM_FWD-1:0][DATA_W-1:0]   fwd_data,
  output logic [DATA_W-1:0]                data,
  output logic                             hit
);
  // Scan oldest to youngest so the lowest matching index is applied last and wins.
  always_comb begin
    data = raw_data;
    hit  = 1'b0;
    for (int j = NUM_FWD - 1; j >= 0; j--) begin
      if (addr != ADDR_W'(REG_ZERO) && fwd_valid[j] && fwd_addr[j] == addr) begin
        data = fwd_data[j];
        hit  = 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/dx_stage_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dx_stage_reg : decode-to-execute register with forwarding and refresh  |
// | Revision     : 1.0                                                     |
// +-----------------------------------------------------------------------+
module dx_stage_reg
  import stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int PC_W    = 32,
  parameter int CTRL_W  = 16,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  dx_stage_reg_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                           valid_q,    valid_d;
  logic [PC_W-1:0]                pc_q,       pc_d;
  logic [CTRL_W-1:0]              ctrl_q,     ctrl_d;
  logic [NUM_SRC-1:0][ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_data_q, src_data_d;
  logic [ADDR_W-1:0]              rd_addr_q,  rd_addr_d;
  logic [DATA_W-1:0]              imm_q,      imm_d;
  logic [NUM_SRC-1:0]             fwd_hit_q,  fwd_hit_d;
  logic [CNT_W-1:0]               cnt_q,      cnt_d;

  logic [DATA_W-1:0] adv_data [NUM_SRC];
  logic              adv_hit  [NUM_SRC];
  logic [DATA_W-1:0] ref_data [NUM_SRC];
  logic              ref_hit  [NUM_SRC];

  // One selector per operand on the incoming instruction, one on the held one.
  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD)) u_adv (
        .addr      (bus.in_src_addr[i]),
        .raw_data  (bus.in_src_data[i]),
        .fwd_valid (bus.fwd_valid),
        .fwd_addr  (bus.fwd_addr),
        .fwd_data  (bus.fwd_data),
        .data      (adv_data[i]),
        .hit       (adv_hit[i])
      );
      fwd_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD)) u_ref (
        .addr      (src_addr_q[i]),
        .raw_data  (src_data_q[i]),
        .fwd_valid (bus.fwd_valid),
        .fwd_addr  (bus.fwd_addr),
        .fwd_data  (bus.fwd_data),
        .data      (ref_data[i]),
        .hit       (ref_hit[i])
      );
    end
  endgenerate

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    ctrl_d     = ctrl_q;
    src_addr_d = src_addr_q;
    src_data_d = src_data_q;
    rd_addr_d  = rd_addr_q;
    imm_d      = imm_q;
    fwd_hit_d  = fwd_hit_q;
    cnt_d      = cnt_q;

    if (bus.flush) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      ctrl_d     = CTRL_W'(CTRL_NOP);
      src_addr_d = '0;
      src_data_d = '0;
      rd_addr_d  = '0;
      imm_d      = '0;
      fwd_hit_d  = '0;
    end else if (bus.stall) begin
      if (valid_q) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        for (int i = 0; i < NUM_SRC; i++) begin
          if (ref_hit[i]) begin
            src_data_d[i] = ref_data[i];
            fwd_hit_d[i]  = 1'b1;
          end
        end
      end
    end else begin
      valid_d    = bus.in_valid;
      pc_d       = bus.in_pc;
      ctrl_d     = bus.in_ctrl;
      src_addr_d = bus.in_src_addr;
      rd_addr_d  = bus.in_rd_addr;
      imm_d      = bus.in_imm;
      for (int i = 0; i < NUM_SRC; i++) begin
        src_data_d[i] = adv_data[i];
        fwd_hit_d[i]  = adv_hit[i];
      end
      // A bubble must not look like it writes anything downstream.
      if (!bus.in_valid) begin
        ctrl_d    = CTRL_W'(CTRL_NOP);
        rd_addr_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      ctrl_q     <= CTRL_W'(CTRL_NOP);
      src_addr_q <= '0;
      src_data_q <= '0;
      rd_addr_q  <= '0;
      imm_q      <= '0;
      fwd_hit_q  <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      ctrl_q     <= ctrl_d;
      src_addr_q <= src_addr_d;
      src_data_q <= src_data_d;
      rd_addr_q  <= rd_addr_d;
      imm_q      <= imm_d;
      fwd_hit_q  <= fwd_hit_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_ctrl     = ctrl_q;
  assign bus.out_src_addr = src_addr_q;
  assign bus.out_src_data = src_data_q;
  assign bus.out_rd_addr  = rd_addr_q;
  assign bus.out_imm      = imm_q;
  assign bus.out_fwd_hit  = fwd_hit_q;
  assign bus.stall_cnt    = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_dx_stage_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_dx_stage_reg : directed and random checks against a stage model     |
// | Revision        : 1.0                                                  |
// +-----------------------------------------------------------------------+
module tb_dx_stage_reg;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int PC_W    = 32;
  localparam int CTRL_W  = 16;
  localparam int NUM_SRC = 2;
  localparam int NUM_FWD = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  dx_stage_reg_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .CTRL_W(CTRL_W),
                    .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) ifc ();

  dx_stage_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .CTRL_W(CTRL_W),
                 .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference state of the execute slot
  bit                m_valid;
  logic [PC_W-1:0]   m_pc;
  logic [CTRL_W-1:0] m_ctrl;
  logic [ADDR_W-1:0] m_src_addr [NUM_SRC];
  logic [DATA_W-1:0] m_src_data [NUM_SRC];
  logic [ADDR_W-1:0] m_rd;
  logic [DATA_W-1:0] m_imm;
  bit                m_hit [NUM_SRC];
  int                m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear_slot();
    m_valid = 0; m_pc = '0; m_ctrl = '0; m_rd = '0; m_imm = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      m_src_addr[i] = '0; m_src_data[i] = '0; m_hit[i] = 0;
    end
  endtask

  task automatic model_reset();
    model_clear_slot();
    m_cnt = 0;
  endtask

  // Youngest valid producer of register a, or -1; register zero is never forwarded.
  function automatic int fwd_index(input logic [ADDR_W-1:0] a);
    int idx = -1;
    if (a == 0) return -1;
    for (int j = 0; j < NUM_FWD; j++)
      if (idx < 0 && ifc.fwd_valid[j] && ifc.fwd_addr[j] == a) idx = j;
    return idx;
  endfunction

  task automatic model_clock();
    int k;
    if (!rst) model_reset();
    else if (ifc.flush) model_clear_slot();
    else if (ifc.stall) begin
      if (m_valid) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        for (int i = 0; i < NUM_SRC; i++) begin
          k = fwd_index(m_src_addr[i]);
          if (k >= 0) begin
            m_src_data[i] = ifc.fwd_data[k];
            m_hit[i] = 1;
          end
        end
      end
    end else begin
      m_valid = ifc.in_valid;
      m_pc    = ifc.in_pc;
      m_ctrl  = ifc.in_valid ? ifc.in_ctrl : '0;
      m_rd    = ifc.in_valid ? ifc.in_rd_addr : '0;
      m_imm   = ifc.in_imm;
      for (int i = 0; i < NUM_SRC; i++) begin
        m_src_addr[i] = ifc.in_src_addr[i];
        k = fwd_index(ifc.in_src_addr[i]);
        m_src_data[i] = (k >= 0) ? ifc.fwd_data[k] : ifc.in_src_data[i];
        m_hit[i] = (k >= 0);
      end
    end
  endtask

  task automatic compare_all();
    check("valid", ifc.out_valid, m_valid);
    check("pc", ifc.out_pc, m_pc);
    check("ctrl", ifc.out_ctrl, m_ctrl);
    check("rd_addr", ifc.out_rd_addr, m_rd);
    check("imm", ifc.out_imm, m_imm);
    check("stall_cnt", ifc.stall_cnt, m_cnt);
    for (int i = 0; i < NUM_SRC; i++) begin
      check($sformatf("src_addr%0d", i), ifc.out_src_addr[i], m_src_addr[i]);
      check($sformatf("src_data%0d", i), ifc.out_src_data[i], m_src_data[i]);
      check($sformatf("fwd_hit%0d", i), ifc.out_fwd_hit[i], m_hit[i]);
    end
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    ifc.stall = 0; ifc.flush = 0; ifc.in_valid = 0;
    ifc.in_pc = '0; ifc.in_ctrl = '0; ifc.in_rd_addr = '0; ifc.in_imm = '0;
    ifc.in_src_addr = '0; ifc.in_src_data = '0;
    ifc.fwd_valid = '0; ifc.fwd_addr = '0; ifc.fwd_data = '0;
  endtask

  task automatic drive_random();
    ifc.stall    = ($urandom_range(0, 9) < 3);
    ifc.flush    = ($urandom_range(0, 19) == 0);
    ifc.in_valid = ($urandom_range(0, 9) < 8);
    ifc.in_pc    = $urandom;
    ifc.in_ctrl  = CTRL_W'($urandom);
    ifc.in_rd_addr = ADDR_W'($urandom);
    ifc.in_imm   = $urandom;
    ifc.fwd_valid = NUM_FWD'($urandom);
    for (int i = 0; i < NUM_SRC; i++) begin
      ifc.in_src_addr[i] = ADDR_W'($urandom_range(0, 7));
      ifc.in_src_data[i] = $urandom;
    end
    for (int j = 0; j < NUM_FWD; j++) begin
      ifc.fwd_addr[j] = ADDR_W'($urandom_range(0, 7));
      ifc.fwd_data[j] = $urandom;
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();
    step();
    step();
    check("rst_valid", ifc.out_valid, 0);
    #4 rst = 1'b1;

    // Reset then advance
    ifc.in_valid = 1; ifc.in_pc = 32'h40; ifc.in_ctrl = 16'h0001; ifc.in_rd_addr = 5'd5;
    ifc.in_src_addr[0] = 5'd3; ifc.in_src_addr[1] = 5'd4;
    ifc.in_src_data[0] = 32'h11; ifc.in_src_data[1] = 32'h22;
    step();
    check("adv_valid", ifc.out_valid, 1);
    check("adv_data0", ifc.out_src_data[0], 32'h11);
    check("adv_data1", ifc.out_src_data[1], 32'h22);
    check("adv_hit", ifc.out_fwd_hit, 2'b00);

    // Two producers of the same register: index 0 wins
    ifc.in_src_addr[0] = 5'd7;
    ifc.fwd_valid = 2'b11; ifc.fwd_addr[0] = 5'd7; ifc.fwd_addr[1] = 5'd7;
    ifc.fwd_data[0] = 32'hAA; ifc.fwd_data[1] = 32'hBB;
    step();
    check("pri_data0", ifc.out_src_data[0], 32'hAA);
    check("pri_hit0", ifc.out_fwd_hit[0], 1);

    // Register zero never forwards
    ifc.in_src_addr[1] = 5'd0; ifc.in_src_data[1] = 32'h0;
    ifc.fwd_valid = 2'b01; ifc.fwd_addr[0] = 5'd0; ifc.fwd_data[0] = 32'h55;
    step();
    check("r0_data1", ifc.out_src_data[1], 0);
    check("r0_hit1", ifc.out_fwd_hit[1], 0);

    // Stall refresh of a held operand
    idle_inputs();
    ifc.in_valid = 1; ifc.in_pc = 32'h80; ifc.in_ctrl = 16'h00F0;
    ifc.in_src_addr[0] = 5'd9; ifc.in_src_data[0] = 32'h99;
    step();
    ifc.stall = 1; ifc.in_pc = 32'hDEAD; ifc.in_src_data[0] = 32'h77;
    step();
    ifc.fwd_valid = 2'b10; ifc.fwd_addr[1] = 5'd9; ifc.fwd_data[1] = 32'h1234;
    step();
    check("refresh_data0", ifc.out_src_data[0], 32'h1234);
    ifc.fwd_valid = 2'b00;
    step();
    check("refresh_hold0", ifc.out_src_data[0], 32'h1234);
    check("refresh_hit0", ifc.out_fwd_hit[0], 1);
    check("stall_pc", ifc.out_pc, 32'h80);
    check("stall_cnt3", ifc.stall_cnt, 3);

    // Flush beats stall, and an empty stalled slot does not count
    ifc.flush = 1;
    step();
    check("flush_valid", ifc.out_valid, 0);
    check("flush_ctrl", ifc.out_ctrl, 0);
    check("flush_rd", ifc.out_rd_addr, 0);
    ifc.flush = 0;
    step();
    check("flush_cnt", ifc.stall_cnt, 3);

    // Saturation, then asynchronous reset between edges
    ifc.stall = 0; ifc.in_valid = 1;
    step();
    ifc.stall = 1;
    repeat (20) step();
    check("sat_cnt", ifc.stall_cnt, 15);
    #3 rst = 1'b0;
    model_reset();
    #1;
    check("async_valid", ifc.out_valid, 0);
    check("async_cnt", ifc.stall_cnt, 0);
    compare_all();
    #2 rst = 1'b1;
    step();
    check("empty_after_rst", ifc.out_valid, 0);
    check("cnt_after_rst", ifc.stall_cnt, 0);

    // Random traffic with occasional mid-cycle resets
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b0;
        model_reset();
        #1 compare_all();
        #1 rst = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
